// File: rtl/pulse_width_capture_pkg.sv
// ---------------------------------------------------------------------------
// pwc_pkg
// Shared types and constants for the pulse width capture block.
//   pwc_state_t        : capture FSM state encoding
//   PWC_WIDTH_DEFAULT  : default width of the measured tick count
// ---------------------------------------------------------------------------
package pwc_pkg;

   typedef enum logic [1:0] {
      PWC_IDLE,
      PWC_ARMED,
      PWC_MEASURE,
      PWC_DONE
   } pwc_state_t;

   localparam int PWC_WIDTH_DEFAULT = 4;

endpackage

// File: rtl/pulse_width_capture_if.sv
// ---------------------------------------------------------------------------
// pulse_width_capture_if
// Groups the control, line and result signals of pulse_width_capture.
//   clk_en   : tick enable, count advances only when 1
//   start    : one-cycle arm request
//   pulse_in : line being measured
//   ack      : one-cycle result acknowledge
//   width    : measured tick count
//   ovf      : measurement saturated
//   valid    : result available
//   busy     : block is armed or measuring
// Modports: master drives requests and the line, slave is the capture block.
// ---------------------------------------------------------------------------
interface pulse_width_capture_if
   import pwc_pkg::*;
#(
   parameter int WIDTH = PWC_WIDTH_DEFAULT
);

   logic             clk_en;
   logic             start;
   logic             pulse_in;
   logic             ack;
   logic [WIDTH-1:0] width;
   logic             ovf;
   logic             valid;
   logic             busy;

   modport master (
      output clk_en, start, pulse_in, ack,
      input  width, ovf, valid, busy
   );

   modport slave (
      input  clk_en, start, pulse_in, ack,
      output width, ovf, valid, busy
   );

endinterface

// File: rtl/pulse_width_capture_edge_sync.sv
// ---------------------------------------------------------------------------
// pwc_edge_sync
// Produces the sampled line s and its rising/falling edge strobes.
// Optional macro PULSE_WIDTH_CAPTURE_SYNC_EN: when defined, pulse_in is
// passed through a two-flop synchronizer and s is the second flop; when
// undefined, s is pulse_in directly (source must be synchronous to clk).
// Ports:
//   clk      : system clock
//   rst      : asynchronous active-low reset
//   pulse_in : raw line
//   s        : sampled line
//   rise     : s went 0->1 this cycle
//   fall     : s went 1->0 this cycle
// ---------------------------------------------------------------------------
module pwc_edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic pulse_in,
   output logic s,
   output logic rise,
   output logic fall
);

   logic s_prev_q;

`ifdef PULSE_WIDTH_CAPTURE_SYNC_EN
   logic [1:0] sync_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], pulse_in};
      end
   end

   assign s = sync_q[1];
`else
   assign s = pulse_in;
`endif

   // Tracks s in every state so that ARMED can demand a fresh 0->1 edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s_prev_q <= 1'b0;
      end else begin
         s_prev_q <= s;
      end
   end

   assign rise = s & ~s_prev_q;
   assign fall = ~s & s_prev_q;

endmodule

// File: rtl/pulse_width_capture.sv
// ---------------------------------------------------------------------------
// pulse_width_capture
// Measures how many clk_en ticks a pulse on pulse_in stays high and returns
// the count through a valid/ack handshake. The count saturates at all-ones
// and a further increment attempt sets a sticky overflow flag.
// Optional macro PULSE_WIDTH_CAPTURE_SYNC_EN (see pwc_edge_sync) adds a
// two-flop input synchronizer; measured widths are unchanged.
// Ports:
//   clk : system clock
//   rst : asynchronous active-low reset
//   bus : pulse_width_capture_if.slave (clk_en, start, pulse_in, ack in;
//         width, ovf, valid, busy out)
// ---------------------------------------------------------------------------
module pulse_width_capture
   import pwc_pkg::*;
#(
   parameter int WIDTH = PWC_WIDTH_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   pulse_width_capture_if.slave  bus
);

   pwc_state_t       state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             s, rise, fall;

   pwc_edge_sync u_edge (
      .clk      (clk),
      .rst      (rst),
      .pulse_in (bus.pulse_in),
      .s        (s),
      .rise     (rise),
      .fall     (fall)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= PWC_IDLE;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         PWC_IDLE: begin
            if (bus.start) begin
               state_d = PWC_ARMED;
            end
         end
         PWC_ARMED: begin
            // The rise cycle itself is the first high sample, so it counts
            // when it coincides with a tick.
            if (rise) begin
               state_d = PWC_MEASURE;
               count_d = bus.clk_en ? WIDTH'(1) : '0;
               ovf_d   = 1'b0;
            end
         end
         PWC_MEASURE: begin
            if (fall) begin
               state_d = PWC_DONE;
            end else if (s && bus.clk_en) begin
               if (count_q == '1) begin
                  ovf_d = 1'b1;
               end else begin
                  count_d = count_q + WIDTH'(1);
               end
            end
         end
         PWC_DONE: begin
            // ack closes the result; a simultaneous start rearms at once.
            if (bus.ack) begin
               state_d = bus.start ? PWC_ARMED : PWC_IDLE;
            end
         end
         default: begin
            state_d = PWC_IDLE;
         end
      endcase
   end

   assign bus.width = count_q;
   assign bus.ovf   = ovf_q;
   assign bus.valid = (state_q == PWC_DONE);
   assign bus.busy  = (state_q == PWC_ARMED) || (state_q == PWC_MEASURE);

endmodule
